// File: rtl/fpu_operand_queue.sv
// Operand FIFO between instruction issue and the FPU input-conversion stage.
// Optional macro FPU_OPQ_BYPASS_EN enables a zero-latency path when the queue is empty.
module fpu_operand_queue #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_op1,
  input  logic [63:0]              in_op2,
  input  logic [3:0]               in_op_type,
  input  logic                     in_P,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_op1,
  output logic [63:0]              out_op2,
  output logic [3:0]               out_op_type,
  output logic                     out_P,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [3:0]  op_type;
    logic        p;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  entry_t          in_entry;
  entry_t          out_entry;
  logic            stored_valid;
  logic            bypass;
  logic            push_en;
  logic            pop_en;

  assign in_entry     = '{op1: in_op1, op2: in_op2, op_type: in_op_type, p: in_P};
  assign stored_valid = (count_q != '0);
  assign in_ready     = (count_q < DEPTH_C);

`ifdef FPU_OPQ_BYPASS_EN
  assign bypass = (count_q == '0) && in_valid && out_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed operand is consumed on the spot, so it must not also be stored.
  assign push_en = in_valid && in_ready && !bypass;
  assign pop_en  = stored_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is left unreset; outputs are masked to zero whenever no entry is valid.
  always_ff @(posedge clk) begin
    if (push_en && !flush) mem_q[wr_ptr_q] <= in_entry;
  end

  always_comb begin
    out_valid = stored_valid;
    out_entry = stored_valid ? mem_q[rd_ptr_q] : '0;
`ifdef FPU_OPQ_BYPASS_EN
    if (bypass) begin
      out_valid = 1'b1;
      out_entry = in_entry;
    end
`endif
  end

  assign out_op1     = out_entry.op1;
  assign out_op2     = out_entry.op2;
  assign out_op_type = out_entry.op_type;
  assign out_P       = out_entry.p;
  assign count       = count_q;

endmodule

// File: tb/tb_fpu_operand_queue.sv
// Scoreboard bench for fpu_operand_queue: stimulus queues expected entries,
// a negedge monitor compares every consumed head entry in order.
module tb_fpu_operand_queue;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [3:0]  op_type;
    logic        p;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_op1, in_op2;
  logic [3:0]  in_op_type;
  logic        in_P;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_op1, out_op2;
  logic [3:0]  out_op_type;
  logic        out_P;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  entry_t exp_q[$];
  int     mcnt = 0;
  bit     p_push, p_pop, p_fl;

  fpu_operand_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_op_type(in_op_type), .in_P(in_P),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_op_type(out_op_type), .out_P(out_P),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: a head entry is consumed when valid & ready with no flush.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        check("sb_op1", out_op1, e.op1);
        check("sb_op2", out_op2, e.op2);
        check("sb_op_type", 64'(out_op_type), 64'(e.op_type));
        check("sb_P", 64'(out_P), 64'(e.p));
      end
    end
  end

  task automatic apply(input logic iv, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] t, input logic p, input logic ordy, input logic fl);
    bit byp;
    in_valid = iv; in_op1 = a; in_op2 = b; in_op_type = t; in_P = p;
    out_ready = ordy; flush = fl;
    byp = 1'b0;
`ifdef FPU_OPQ_BYPASS_EN
    byp = (mcnt == 0) && iv && ordy && !fl;
`endif
    p_fl   = fl;
    p_push = iv && (mcnt < DEPTH) && !fl && !byp;
    p_pop  = ordy && (mcnt != 0) && !fl;
    if (fl) exp_q.delete();
    if (p_push || byp) exp_q.push_back('{op1: a, op2: b, op_type: t, p: p});
  endtask

  task automatic advance(input string tag);
    @(posedge clk);
    #1;
    if (p_fl) mcnt = 0;
    else      mcnt = mcnt + int'(p_push) - int'(p_pop);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_op1 = '0; in_op2 = '0; in_op_type = '0; in_P = 1'b0;
    check({tag, "_count"}, 64'(count), 64'(mcnt));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(mcnt < DEPTH));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(mcnt != 0));
  endtask

  task automatic step(input string tag, input logic iv, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] t, input logic p, input logic ordy, input logic fl);
    apply(iv, a, b, t, p, ordy, fl);
    advance(tag);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op1 = '0; in_op2 = '0; in_op_type = '0; in_P = 1'b0;
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_op1", out_op1, 64'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // First push, consumer stalled: one-cycle latency, fields intact.
    step("push1", 1, 64'h4000000000000000, 64'h3FF0000000000000, 4'h0, 0, 0, 0);
    check("push1_op1", out_op1, 64'h4000000000000000);
    check("push1_op2", out_op2, 64'h3FF0000000000000);
    check("push1_type", 64'(out_op_type), 64'd0);
    check("push1_P", 64'(out_P), 64'd0);
    step("stall", 0, 0, 0, 0, 0, 0, 0);
    check("stall_op1", out_op1, 64'h4000000000000000);

    // Push and pop together at count 1: new entry becomes head.
    step("pushpop", 1, 64'h3F80000000000000, 64'h4040000000000000, 4'h3, 1, 1, 0);
    check("pushpop_head_op1", out_op1, 64'h3F80000000000000);
    check("pushpop_head_P", 64'(out_P), 64'd1);
    step("drain1", 0, 0, 0, 0, 0, 1, 0);
    check("empty_op1_zero", out_op1, 64'd0);
    check("empty_type_zero", 64'(out_op_type), 64'd0);
    step("empty_pop", 0, 0, 0, 0, 0, 1, 0);

    // Fill to DEPTH, third push refused, full+pop still refuses the push.
    step("fill1", 1, 64'hC000000000000000, 64'h0000000000000001, 4'h1, 0, 0, 0);
    step("fill2", 1, 64'h7FF0000000000000, 64'h8000000000000000, 4'h2, 0, 0, 0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step("fill3", 1, 64'hDEADBEEFDEADBEEF, 64'h1234567812345678, 4'hF, 1, 0, 0);
    step("fullpop", 1, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 4'hE, 1, 1, 0);
    check("fullpop_head_op1", out_op1, 64'h7FF0000000000000);
    step("drain2", 0, 0, 0, 0, 0, 1, 0);

    // Flush at count 2 beats a concurrent push.
    step("pre_fl1", 1, 64'h0000000000000011, 64'h0000000000000022, 4'h4, 0, 0, 0);
    step("pre_fl2", 1, 64'h0000000000000033, 64'h0000000000000044, 4'h5, 1, 0, 0);
    step("flush", 1, 64'h0000000000000055, 64'h0000000000000066, 4'h6, 0, 1, 1);
    check("flush_op1_zero", out_op1, 64'd0);
    check("flush_op2_zero", out_op2, 64'd0);
    step("post_fl", 1, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 4'h7, 1, 0, 0);
    check("post_fl_op1", out_op1, 64'h0123456789ABCDEF);
    step("post_fl_drain", 0, 0, 0, 0, 0, 1, 0);

    // Asynchronous reset between edges with two entries held.
    step("pre_rst1", 1, 64'h1111111111111111, 64'h2222222222222222, 4'h8, 0, 0, 0);
    step("pre_rst2", 1, 64'h3333333333333333, 64'h4444444444444444, 4'h9, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_op1_zero", out_op1, 64'd0);
    exp_q.delete();
    mcnt = 0;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Empty queue with producer and consumer both ready.
    apply(1, 64'h000000000000ABCD, 64'h000000000000DCBA, 4'b0101, 1, 1, 0);
    #1;
`ifdef FPU_OPQ_BYPASS_EN
    check("byp_out_valid", 64'(out_valid), 64'd1);
    check("byp_out_type", 64'(out_op_type), 64'b0101);
    check("byp_count", 64'(count), 64'd0);
`else
    check("nobyp_out_valid", 64'(out_valid), 64'd0);
`endif
    advance("byp");
    step("byp_drain", 0, 0, 0, 0, 0, 1, 0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
